// File: rtl/homo_pkg.sv
// Shared types for the homography display path: coordinate width,
// RGB565 colour fields and the coordinate/colour payload structs.
package homo_pkg;

    localparam int unsigned CW  = 10;
    localparam int unsigned R_W = 5;
    localparam int unsigned G_W = 6;
    localparam int unsigned B_W = 5;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } coord_t;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

endpackage

// File: rtl/homography_arbiter_tag_fifo.sv
// tag_fifo: synchronous FIFO of power-of-two depth holding the issue-order
// tags of outstanding engine queries; push and pop may coincide when full or empty.
module tag_fifo #(
    parameter int unsigned  DEPTH = 8,
    parameter int unsigned  WIDTH = 1,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk_25,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNTW-1:0]  count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees the slot a same-cycle push lands in, so push-when-full is legal with pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_25) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/homography_arbiter.sv
// Round-robin arbiter sharing one pipelined homography engine between two requesters,
// with in-order response routing. Define HOMO_ARB_CHECK_EN to also check returned x,y.
module homography_arbiter
    import homo_pkg::*;
#(
    parameter int unsigned  MAX_OUT = 8,
    parameter int unsigned  CW      = homo_pkg::CW,
    localparam int unsigned OW      = $clog2(MAX_OUT + 1)
) (
    input  logic           clk_25,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    input  logic [CW-1:0]  req_x0,
    input  logic [CW-1:0]  req_y0,
    input  logic [CW-1:0]  req_x1,
    input  logic [CW-1:0]  req_y1,
    output logic [1:0]     req_grant,
    output logic [1:0]     resp_valid,
    output logic [CW-1:0]  resp_x,
    output logic [CW-1:0]  resp_y,
    output logic [R_W-1:0] resp_r,
    output logic [G_W-1:0] resp_g,
    output logic [B_W-1:0] resp_b,
    output logic [CW-1:0]  query_x,
    output logic [CW-1:0]  query_y,
    output logic           start,
    input  logic [CW-1:0]  return_x,
    input  logic [CW-1:0]  return_y,
    input  logic [R_W-1:0] r,
    input  logic [G_W-1:0] g,
    input  logic [B_W-1:0] b,
    input  logic           ready,
    output logic [OW-1:0]  outstanding,
    output logic           debug
);

`ifdef HOMO_ARB_CHECK_EN
    localparam int unsigned QW = 1 + 2 * CW;
`else
    localparam int unsigned QW = 1;
`endif

    logic          q_full;
    logic          q_empty;
    logic          q_push;
    logic          q_pop;
    logic [QW-1:0] q_wdata;
    logic [QW-1:0] q_rdata;
    logic          q_tag;
    logic          mismatch_c;
    logic          last;
    logic          sel;
    logic          transfer;
    logic [CW-1:0] sel_x;
    logic [CW-1:0] sel_y;
    rgb565_t       eng_rgb;

    // Grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        req_grant = 2'b00;
        if (rst_n && !q_full) begin
            case (req_valid)
                2'b01:   req_grant = 2'b01;
                2'b10:   req_grant = 2'b10;
                2'b11:   req_grant = last ? 2'b01 : 2'b10;
                default: req_grant = 2'b00;
            endcase
        end
    end

    assign transfer = |(req_valid & req_grant);
    assign sel      = req_grant[1];
    assign sel_x    = sel ? req_x1 : req_x0;
    assign sel_y    = sel ? req_y1 : req_y0;
    assign q_push   = transfer;
    assign q_pop    = ready && !q_empty;
    assign eng_rgb  = '{r: r, g: g, b: b};

`ifdef HOMO_ARB_CHECK_EN
    assign q_wdata    = {sel, sel_x, sel_y};
    assign q_tag      = q_rdata[QW-1];
    assign mismatch_c = (q_rdata[2*CW-1:CW] != return_x) || (q_rdata[CW-1:0] != return_y);
`else
    assign q_wdata    = sel;
    assign q_tag      = q_rdata[0];
    assign mismatch_c = 1'b0;
`endif

    tag_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (QW)
    ) u_tag_fifo (
        .clk_25 (clk_25),
        .rst_n  (rst_n),
        .push   (q_push),
        .wdata  (q_wdata),
        .pop    (q_pop),
        .rdata  (q_rdata),
        .full   (q_full),
        .empty  (q_empty),
        .count  (outstanding)
    );

    // Engine query side and round-robin pointer; last=1 lets requester 0 win the first tie.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            start   <= 1'b0;
            query_x <= '0;
            query_y <= '0;
            last    <= 1'b1;
        end else begin
            start <= transfer;
            if (transfer) begin
                query_x <= sel_x;
                query_y <= sel_y;
                last    <= sel;
            end
        end
    end

    // Response routing; data buses hold between pulses.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 2'b00;
            resp_x     <= '0;
            resp_y     <= '0;
            resp_r     <= '0;
            resp_g     <= '0;
            resp_b     <= '0;
        end else begin
            resp_valid <= 2'b00;
            if (q_pop) begin
                resp_valid <= q_tag ? 2'b10 : 2'b01;
                resp_x     <= return_x;
                resp_y     <= return_y;
                resp_r     <= eng_rgb.r;
                resp_g     <= eng_rgb.g;
                resp_b     <= eng_rgb.b;
            end
        end
    end

    // Sticky error: result with nothing outstanding, or returned coordinates not matching the query.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            debug <= 1'b0;
        end else if ((ready && q_empty) || (q_pop && mismatch_c)) begin
            debug <= 1'b1;
        end
    end

endmodule

// File: tb/tb_homography_arbiter.sv
// Scoreboard bench for homography_arbiter: directed stimulus pushes expected
// queries/responses; a negedge monitor pops and compares them.
module tb_homography_arbiter;

    localparam int unsigned CW = 10;

    typedef struct {
        bit           tag;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } qent_t;

    typedef struct {
        logic [1:0]    vld;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [4:0]    r;
        logic [5:0]    g;
        logic [4:0]    b;
    } rexp_t;

    logic          clk_25 = 1'b0;
    logic          rst_n  = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [CW-1:0] req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
    logic [1:0]    req_grant;
    logic [1:0]    resp_valid;
    logic [CW-1:0] resp_x, resp_y;
    logic [4:0]    resp_r;
    logic [5:0]    resp_g;
    logic [4:0]    resp_b;
    logic [CW-1:0] query_x, query_y;
    logic          start;
    logic [CW-1:0] return_x = '0, return_y = '0;
    logic [4:0]    r = '0;
    logic [5:0]    g = '0;
    logic [4:0]    b = '0;
    logic          ready = 1'b0;
    logic [3:0]    outstanding;
    logic          debug;

    int n_tests = 0;
    int n_fail  = 0;

    qent_t mq[$];
    qent_t qq[$];
    rexp_t rq[$];

    logic [CW-1:0] cx0, cy0, cx1, cy1;
    logic [4:0]    rc = 5'd3;
    logic [5:0]    gc = 6'd9;
    logic [4:0]    bc = 5'd17;

    homography_arbiter #(.MAX_OUT(8), .CW(CW)) dut (
        .clk_25      (clk_25),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_x0      (req_x0),
        .req_y0      (req_y0),
        .req_x1      (req_x1),
        .req_y1      (req_y1),
        .req_grant   (req_grant),
        .resp_valid  (resp_valid),
        .resp_x      (resp_x),
        .resp_y      (resp_y),
        .resp_r      (resp_r),
        .resp_g      (resp_g),
        .resp_b      (resp_b),
        .query_x     (query_x),
        .query_y     (query_y),
        .start       (start),
        .return_x    (return_x),
        .return_y    (return_y),
        .r           (r),
        .g           (g),
        .b           (b),
        .ready       (ready),
        .outstanding (outstanding),
        .debug       (debug)
    );

    always #20 clk_25 = ~clk_25;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check grant/occupancy, record expectations.
    task automatic cyc(input logic [1:0] v, input logic [1:0] eg, input bit rdy,
                       input int eocc, input bit bad = 1'b0);
        qent_t e;
        rexp_t re;
        @(posedge clk_25);
        #1;
        req_valid = v;
        req_x0 = cx0; req_y0 = cy0; req_x1 = cx1; req_y1 = cy1;
        ready = rdy;
        r = rc; g = gc; b = bc;
        if (rdy && mq.size() > 0) begin
            e = mq.pop_front();
            return_x = e.x;
            return_y = bad ? e.y + 10'd1 : e.y;
            re.vld = e.tag ? 2'b10 : 2'b01;
            re.x = return_x; re.y = return_y;
            re.r = rc; re.g = gc; re.b = bc;
            rq.push_back(re);
        end else if (rdy) begin
            return_x = 10'd999;
            return_y = 10'd998;
        end
        #1;
        chk("grant", int'(req_grant), int'(eg));
        chk("outstanding", int'(outstanding), eocc);
        if (eg == 2'b01) begin
            e.tag = 1'b0; e.x = cx0; e.y = cy0;
            mq.push_back(e); qq.push_back(e);
        end else if (eg == 2'b10) begin
            e.tag = 1'b1; e.x = cx1; e.y = cy1;
            mq.push_back(e); qq.push_back(e);
        end
        cx0 = cx0 + 10'd1; cy0 = cy0 + 10'd2; cx1 = cx1 + 10'd3; cy1 = cy1 + 10'd5;
        rc = rc + 5'd1; gc = gc + 6'd3; bc = bc + 5'd7;
    endtask

    task automatic do_reset();
        @(posedge clk_25);
        #1;
        rst_n = 1'b0;
        req_valid = 2'b11;
        ready = 1'b0;
        #1;
        chk("grant_in_reset", int'(req_grant), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_outstanding", int'(outstanding), 0);
        chk("rst_debug", int'(debug), 0);
        chk("rst_query_x", int'(query_x), 0);
        @(posedge clk_25);
        #1;
        rst_n = 1'b1;
        req_valid = 2'b00;
        mq.delete();
    endtask

    // Monitor: compare every start and every response against the queues.
    always @(negedge clk_25) begin
        if (rst_n) begin
            if (start) begin
                if (qq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_start: query %0d,%0d with none expected", query_x, query_y);
                end else begin
                    qent_t e;
                    e = qq.pop_front();
                    chk("query_x", int'(query_x), int'(e.x));
                    chk("query_y", int'(query_y), int'(e.y));
                end
            end
            if (resp_valid != 2'b00) begin
                if (rq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_resp: resp_valid %b with none expected", resp_valid);
                end else begin
                    rexp_t re;
                    re = rq.pop_front();
                    chk("resp_valid", int'(resp_valid), int'(re.vld));
                    chk("resp_x", int'(resp_x), int'(re.x));
                    chk("resp_y", int'(resp_y), int'(re.y));
                    chk("resp_rgb", int'({resp_r, resp_g, resp_b}), int'({re.r, re.g, re.b}));
                end
            end
        end
    end

    initial begin
        cx0 = 10'd12; cy0 = 10'd34; cx1 = 10'd200; cy1 = 10'd300;
        do_reset();

        // Single requester, engine answers 5 cycles after the transfer.
        cyc(2'b01, 2'b01, 1'b0, 0);
        for (int i = 0; i < 4; i++) cyc(2'b00, 2'b00, 1'b0, 1);
        cyc(2'b00, 2'b00, 1'b1, 1);
        cyc(2'b00, 2'b00, 1'b0, 0);
        cyc(2'b00, 2'b00, 1'b0, 0);

        // Tie for 4 cycles right after reset: grants 0,1,0,1.
        do_reset();
        cyc(2'b11, 2'b01, 1'b0, 0);
        cyc(2'b11, 2'b10, 1'b0, 1);
        cyc(2'b11, 2'b01, 1'b0, 2);
        cyc(2'b11, 2'b10, 1'b0, 3);
        cyc(2'b00, 2'b00, 1'b1, 4);
        cyc(2'b00, 2'b00, 1'b1, 3);
        cyc(2'b00, 2'b00, 1'b1, 2);
        cyc(2'b00, 2'b00, 1'b1, 1);
        cyc(2'b00, 2'b00, 1'b0, 0);

        // Fill to MAX_OUT with the engine stalled.
        for (int i = 0; i < 8; i++)
            cyc(2'b11, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, i);
        cyc(2'b11, 2'b00, 1'b0, 8);
        cyc(2'b11, 2'b00, 1'b1, 8);
        cyc(2'b11, 2'b01, 1'b0, 7);

        // Drain to 3, then push and pop in the same cycle.
        for (int i = 0; i < 5; i++) cyc(2'b00, 2'b00, 1'b1, 8 - i);
        cyc(2'b11, 2'b10, 1'b1, 3);
        cyc(2'b00, 2'b00, 1'b0, 3);
        cyc(2'b00, 2'b00, 1'b1, 3);
        cyc(2'b00, 2'b00, 1'b1, 2);
        cyc(2'b00, 2'b00, 1'b1, 1);
        cyc(2'b00, 2'b00, 1'b0, 0);
        chk("debug_clean", int'(debug), 0);

        // Spurious ready on an empty queue.
        cyc(2'b00, 2'b00, 1'b1, 0);
        cyc(2'b00, 2'b00, 1'b0, 0);
        chk("debug_set", int'(debug), 1);
        for (int i = 0; i < 3; i++) cyc(2'b00, 2'b00, 1'b0, 0);
        chk("debug_sticky", int'(debug), 1);
        do_reset();

        // Engine returns wrong y for the query.
        cx0 = 10'd12; cy0 = 10'd34;
        cyc(2'b01, 2'b01, 1'b0, 0);
        cyc(2'b00, 2'b00, 1'b0, 1);
        cyc(2'b00, 2'b00, 1'b1, 1, 1'b1);
        cyc(2'b00, 2'b00, 1'b0, 0);
`ifdef HOMO_ARB_CHECK_EN
        chk("debug_mismatch", int'(debug), 1);
`else
        chk("debug_mismatch", int'(debug), 0);
`endif
        cyc(2'b00, 2'b00, 1'b0, 0);
        cyc(2'b00, 2'b00, 1'b0, 0);

        chk("query_queue_empty", qq.size(), 0);
        chk("resp_queue_empty", rq.size(), 0);
        chk("tag_model_empty", mq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
